// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle,
// early completion for divide-by-zero and signed overflow, flushable.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | XLEN shift-add (mul) or restoring shift-subtract (div) steps
// FIX   | apply result signs and select the output word
// DONE  | one-cycle response pulse
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_a_i,
  input  logic [XLEN-1:0] req_b_i,
  input  logic [TAGW-1:0] req_tag_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_result_o,
  output logic [TAGW-1:0] resp_tag_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0]   ONE      = XLEN'(1);
  localparam logic [XLEN-1:0]   ONES     = '1;
  localparam logic [XLEN-1:0]   MIN      = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2*XLEN-1:0] ONE2     = (2*XLEN)'(1);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [TAGW-1:0]   tag_q, resp_tag_q;
  logic [XLEN-1:0]   b_q, result_q;
  logic              neg_q, rem_neg_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;

  // Request decode: operand signedness, magnitudes and early-exit cases.
  logic            sgn_a, sgn_b, a_neg, b_neg, is_div, div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  assign is_div   = req_op_i[2];
  assign sgn_a    = (req_op_i == OP_MULH) || (req_op_i == OP_MULHSU) ||
                    (req_op_i == OP_DIV)  || (req_op_i == OP_REM);
  assign sgn_b    = (req_op_i == OP_MULH) || (req_op_i == OP_DIV) || (req_op_i == OP_REM);
  assign a_neg    = sgn_a & req_a_i[XLEN-1];
  assign b_neg    = sgn_b & req_b_i[XLEN-1];
  assign abs_a    = a_neg ? (~req_a_i + ONE) : req_a_i;
  assign abs_b    = b_neg ? (~req_b_i + ONE) : req_b_i;
  assign div_zero = is_div && (req_b_i == '0);
  assign div_ovf  = ((req_op_i == OP_DIV) || (req_op_i == OP_REM)) &&
                    (req_a_i == MIN) && (req_b_i == ONES);
  assign special  = div_zero | div_ovf;
  // op[1] separates REM* from DIV* within the divide group
  assign special_res = div_zero ? (req_op_i[1] ? req_a_i : ONES)
                                : (req_op_i[1] ? '0 : MIN);
  assign accept   = (state_q == IDLE) && req_valid_i && !flush_i;

  // One iteration step. acc_q holds {hi, lo}: product for mul, {remainder, quotient} for div.
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_ge   = ~div_diff[XLEN];
  assign div_next = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

  // Sign fix-up and result selection.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  assign prod_fix = neg_q ? (~acc_q + ONE2) : acc_q;
  assign quot_fix = neg_q ? (~acc_q[XLEN-1:0] + ONE) : acc_q[XLEN-1:0];
  assign rem_fix  = rem_neg_q ? (~acc_q[2*XLEN-1:XLEN] + ONE) : acc_q[2*XLEN-1:XLEN];

  // Pick the output word for the operation in flight.
  always_comb begin
    fix_res = prod_fix[2*XLEN-1:XLEN];
    if (op_q == OP_MUL)     fix_res = prod_fix[XLEN-1:0];
    else if (op_q[2])       fix_res = op_q[1] ? rem_fix : quot_fix;
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Datapath: capture at accept, iterate in CALC, publish in FIX.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q       <= '0;
      tag_q      <= '0;
      resp_tag_q <= '0;
      b_q        <= '0;
      result_q   <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
    end else if (accept) begin
      op_q      <= req_op_i;
      tag_q     <= req_tag_i;
      b_q       <= abs_b;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      cnt_q     <= '0;
      acc_q     <= {{XLEN{1'b0}}, abs_a};
      if (special) begin
        result_q   <= special_res;
        resp_tag_q <= req_tag_i;
      end
    end else if (!flush_i) begin
      if (state_q == CALC) begin
        acc_q <= op_q[2] ? div_next : mul_next;
        cnt_q <= cnt_q + CW'(1);
      end else if (state_q == FIX) begin
        result_q   <= fix_res;
        resp_tag_q <= tag_q;
      end
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign resp_valid_o  = (state_q == DONE);
  assign resp_result_o = result_q;
  assign resp_tag_o    = resp_tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, flush/reset sequences,
// and random operations checked against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_op_i;
  logic [31:0] req_a_i, req_b_i;
  logic [4:0]  req_tag_i;
  logic        flush_i;
  logic        resp_valid_o;
  logic [31:0] resp_result_o;
  logic [4:0]  resp_tag_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.XLEN(32), .TAGW(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i), .flush_i(flush_i),
    .resp_valid_o(resp_valid_o), .resp_result_o(resp_result_o),
    .resp_tag_o(resp_tag_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    logic [63:0]     w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    w  = '0;
    case (op)
      3'd0: begin up = ua * ub; w = up; return w[31:0]; end
      3'd1: begin sp = sa * sb; w = sp; return w[63:32]; end
      3'd2: begin sp = sa * longint'(ub); w = sp; return w[63:32]; end
      3'd3: begin up = ua * ub; w = up; return w[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sa / sb; w = sp; return w[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; up = ua / ub; w = up; return w[31:0]; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sp = sa % sb; w = sp; return w[31:0];
      end
      default: begin if (b == 0) return a; up = ua % ub; w = up; return w[31:0]; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one request (called #1 after an edge with the unit idle) and check its response.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp_res, input int exp_lat);
    int k;
    bit got, busy_ok;
    req_valid_i = 1'b1; req_op_i = op; req_a_i = a; req_b_i = b; req_tag_i = tag;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; req_a_i = $urandom; req_b_i = $urandom; req_tag_i = 5'($urandom);
    k = 1; got = 1'b0; busy_ok = 1'b1;
    while (k <= 100 && !got) begin
      if (!busy_o) busy_ok = 1'b0;
      if (resp_valid_o) got = 1'b1;
      else begin @(posedge clk_i); #1; k++; end
    end
    check({nm, "_done"}, 64'(got), 64'd1);
    if (got) begin
      check({nm, "_lat"},  64'(k), 64'(exp_lat));
      check({nm, "_res"},  64'(resp_result_o), 64'(exp_res));
      check({nm, "_tag"},  64'(resp_tag_o), 64'(tag));
      check({nm, "_busy"}, 64'(busy_ok), 64'd1);
    end
    @(posedge clk_i); #1;
    check({nm, "_ready"}, 64'(req_ready_o), 64'd1);
  endtask

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit resp_seen;
    vecs.push_back('{"mul_7xm3",     3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34});
    vecs.push_back('{"mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 34});
    vecs.push_back('{"mulhu_min",    3'd3, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 34});
    vecs.push_back('{"mulhsu_m1x2",  3'd2, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF, 34});
    vecs.push_back('{"divu_100_7",   3'd5, 32'd100,        32'd7,         5'd4,  32'd14,        34});
    vecs.push_back('{"remu_100_7",   3'd7, 32'd100,        32'd7,         5'd6,  32'd2,         34});
    vecs.push_back('{"div_m100_7",   3'd4, 32'hFFFF_FF9C, 32'd7,         5'd7,  32'hFFFF_FFF2, 34});
    vecs.push_back('{"rem_m100_7",   3'd6, 32'hFFFF_FF9C, 32'd7,         5'd8,  32'hFFFF_FFFE, 34});
    vecs.push_back('{"div_5_0",      3'd4, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1});
    vecs.push_back('{"rem_5_0",      3'd6, 32'd5,          32'd0,         5'd10, 32'd5,         1});
    vecs.push_back('{"divu_5_0",     3'd5, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 1});
    vecs.push_back('{"remu_5_0",     3'd7, 32'd5,          32'd0,         5'd12, 32'd5,         1});
    vecs.push_back('{"div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1});
    vecs.push_back('{"rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1});
    vecs.push_back('{"divu_big",     3'd5, 32'hFFFF_FFFF, 32'd1,         5'd15, 32'hFFFF_FFFF, 34});
    vecs.push_back('{"rem_7_m2",     3'd6, 32'd7,          32'hFFFF_FFFE, 5'd16, 32'd1,         34});

    rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
    req_tag_i = '0; flush_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready",  64'(req_ready_o),   64'd1);
    check("rst_busy",   64'(busy_o),        64'd0);
    check("rst_valid",  64'(resp_valid_o),  64'd0);
    check("rst_result", 64'(resp_result_o), 64'd0);
    check("rst_tag",    64'(resp_tag_o),    64'd0);
    rst_i = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp, vecs[i].lat);

    // Flush in cycle 10 of a DIV, then an immediate MUL.
    req_valid_i = 1'b1; req_op_i = 3'd4; req_a_i = 32'd1000; req_b_i = 32'd3; req_tag_i = 5'd20;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    resp_seen = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (resp_valid_o) resp_seen = 1'b1;
      @(posedge clk_i); #1;
    end
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("flush_busy",  64'(busy_o),       64'd0);
    check("flush_ready", 64'(req_ready_o),  64'd1);
    check("flush_noresp", 64'(resp_seen | resp_valid_o), 64'd0);
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd21, 32'd12, 34);

    // Flush together with a request in IDLE: not accepted.
    req_valid_i = 1'b1; flush_i = 1'b1; req_op_i = 3'd4; req_a_i = 32'd5; req_b_i = 32'd0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; flush_i = 1'b0;
    check("flushreq_busy",  64'(busy_o),       64'd0);
    check("flushreq_valid", 64'(resp_valid_o), 64'd0);

    // Asynchronous reset mid-CALC.
    req_valid_i = 1'b1; req_op_i = 3'd0; req_a_i = 32'd11; req_b_i = 32'd13; req_tag_i = 5'd22;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    check("arst_ready",  64'(req_ready_o),   64'd1);
    check("arst_busy",   64'(busy_o),        64'd0);
    check("arst_valid",  64'(resp_valid_o),  64'd0);
    check("arst_result", 64'(resp_result_o), 64'd0);
    check("arst_tag",    64'(resp_tag_o),    64'd0);
    #2 rst_i = 1'b0;
    @(posedge clk_i); #1;
    run_op("divu_9_3", 3'd5, 32'd9, 32'd3, 5'd23, 32'd3, 34);

    // Random operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          sel;
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = int'($urandom_range(0, 15));
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel < 5) b = 32'($urandom_range(1, 20));
      else if (sel < 7) a = 32'($urandom_range(0, 50));
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, 5'($urandom),
             ref_model(op, a, b), ref_latency(op, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
